// File: rtl/stage6_bsn4_seq_check.sv
// Stage 6: per-lane BSN4 sequence checker for the three message lanes.
// Flags in-order, gap and stale/duplicate messages and keeps saturating gap counts.
module stage6_bsn4_seq_check #(
   parameter int unsigned     BSN_W  = 32,
   parameter int unsigned     MUXW   = 4,
   parameter int unsigned     NTW    = 4,
   parameter logic [MUXW-1:0] MUX_N  = MUXW'(1),
   parameter logic [NTW-1:0]  TYPE_M = NTW'(1),
   parameter int unsigned     CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             message_en,
   input  logic [MUXW-1:0]  message_mux_control_m1,
   input  logic [MUXW-1:0]  message_mux_control_m2,
   input  logic [MUXW-1:0]  message_mux_control_m3,
   input  logic [NTW-1:0]   N_type_control_m1,
   input  logic [NTW-1:0]   N_type_control_m2,
   input  logic [NTW-1:0]   N_type_control_m3,
   input  logic [BSN_W-1:0] BSN4_1,
   input  logic [BSN_W-1:0] BSN4_2,
   input  logic [BSN_W-1:0] BSN4_3,
   input  logic             resync,
   output logic [BSN_W-1:0] bsn4_q_1,
   output logic [BSN_W-1:0] bsn4_q_2,
   output logic [BSN_W-1:0] bsn4_q_3,
   output logic             seq_vld_1,
   output logic             seq_vld_2,
   output logic             seq_vld_3,
   output logic             seq_ok_1,
   output logic             seq_ok_2,
   output logic             seq_ok_3,
   output logic             seq_gap_1,
   output logic             seq_gap_2,
   output logic             seq_gap_3,
   output logic             seq_dup_1,
   output logic             seq_dup_2,
   output logic             seq_dup_3,
   output logic [BSN_W-1:0] gap_len_1,
   output logic [BSN_W-1:0] gap_len_2,
   output logic [BSN_W-1:0] gap_len_3,
   output logic [CNT_W-1:0] gap_cnt_1,
   output logic [CNT_W-1:0] gap_cnt_2,
   output logic [CNT_W-1:0] gap_cnt_3
);

   typedef enum logic {UNSYNC, TRACK} state_t;

   state_t           state  [3];
   logic [BSN_W-1:0] expn   [3];
   logic [BSN_W-1:0] bsn    [3];
   logic [BSN_W-1:0] diff   [3];
   logic [BSN_W-1:0] q_r    [3];
   logic [BSN_W-1:0] glen_r [3];
   logic [CNT_W-1:0] cnt_r  [3];
   logic [2:0]       v;
   logic [2:0]       vld_r, ok_r, gap_r, dup_r;

   assign v[0] = message_en && (message_mux_control_m1 == MUX_N) && (N_type_control_m1 == TYPE_M);
   assign v[1] = message_en && (message_mux_control_m2 == MUX_N) && (N_type_control_m2 == TYPE_M);
   assign v[2] = message_en && (message_mux_control_m3 == MUX_N) && (N_type_control_m3 == TYPE_M);
   assign bsn[0] = BSN4_1;
   assign bsn[1] = BSN4_2;
   assign bsn[2] = BSN4_3;

   // Modular distance from the expected BSN; the MSB separates forward gaps from stale values.
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         diff[i] = bsn[i] - expn[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_r <= '0;
         ok_r  <= '0;
         gap_r <= '0;
         dup_r <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            state[i]  <= UNSYNC;
            expn[i]   <= '0;
            q_r[i]    <= '0;
            glen_r[i] <= '0;
            cnt_r[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            vld_r[i]  <= v[i];
            ok_r[i]   <= 1'b0;
            gap_r[i]  <= 1'b0;
            dup_r[i]  <= 1'b0;
            glen_r[i] <= '0;
            if (v[i]) begin
               q_r[i] <= bsn[i];
               // resync coinciding with a valid message treats it as the first after sync
               if (resync || state[i] == UNSYNC) begin
                  ok_r[i]  <= 1'b1;
                  expn[i]  <= bsn[i] + 1'b1;
                  state[i] <= TRACK;
               end else if (diff[i] == '0) begin
                  ok_r[i] <= 1'b1;
                  expn[i] <= expn[i] + 1'b1;
               end else if (!diff[i][BSN_W-1]) begin
                  gap_r[i]  <= 1'b1;
                  glen_r[i] <= diff[i];
                  expn[i]   <= bsn[i] + 1'b1;
                  if (cnt_r[i] != '1) cnt_r[i] <= cnt_r[i] + 1'b1;
               end else begin
                  dup_r[i] <= 1'b1;
               end
            end else if (resync) begin
               state[i] <= UNSYNC;
            end
         end
      end
   end

   assign bsn4_q_1  = q_r[0];
   assign bsn4_q_2  = q_r[1];
   assign bsn4_q_3  = q_r[2];
   assign seq_vld_1 = vld_r[0];
   assign seq_vld_2 = vld_r[1];
   assign seq_vld_3 = vld_r[2];
   assign seq_ok_1  = ok_r[0];
   assign seq_ok_2  = ok_r[1];
   assign seq_ok_3  = ok_r[2];
   assign seq_gap_1 = gap_r[0];
   assign seq_gap_2 = gap_r[1];
   assign seq_gap_3 = gap_r[2];
   assign seq_dup_1 = dup_r[0];
   assign seq_dup_2 = dup_r[1];
   assign seq_dup_3 = dup_r[2];
   assign gap_len_1 = glen_r[0];
   assign gap_len_2 = glen_r[1];
   assign gap_len_3 = glen_r[2];
   assign gap_cnt_1 = cnt_r[0];
   assign gap_cnt_2 = cnt_r[1];
   assign gap_cnt_3 = cnt_r[2];

endmodule

// File: tb/tb_stage6_bsn4_seq_check.sv
// Scoreboard bench for stage6_bsn4_seq_check: directed test-plan sequences then random traffic.
module tb_stage6_bsn4_seq_check;

   localparam int CW = 2;

   logic        clk = 1'b0;
   logic        rst, en, resync;
   logic [3:0]  mux [3];
   logic [3:0]  nt  [3];
   logic [31:0] bsn [3];

   logic [31:0]   q_o    [3];
   logic [31:0]   glen_o [3];
   logic [CW-1:0] cnt_o  [3];
   logic [2:0]    vld_o, ok_o, gap_o, dup_o;

   typedef struct {
      logic [31:0] b;
      bit          ok, gap, dup;
      logic [31:0] glen;
      int          cnt;
   } exp_t;

   exp_t        sbq [3][$];
   bit          synced [3];
   logic [31:0] ex_m   [3];
   logic [31:0] hq     [3];
   int          hcnt   [3];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   stage6_bsn4_seq_check #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .message_en(en),
      .message_mux_control_m1(mux[0]), .message_mux_control_m2(mux[1]), .message_mux_control_m3(mux[2]),
      .N_type_control_m1(nt[0]), .N_type_control_m2(nt[1]), .N_type_control_m3(nt[2]),
      .BSN4_1(bsn[0]), .BSN4_2(bsn[1]), .BSN4_3(bsn[2]),
      .resync(resync),
      .bsn4_q_1(q_o[0]), .bsn4_q_2(q_o[1]), .bsn4_q_3(q_o[2]),
      .seq_vld_1(vld_o[0]), .seq_vld_2(vld_o[1]), .seq_vld_3(vld_o[2]),
      .seq_ok_1(ok_o[0]), .seq_ok_2(ok_o[1]), .seq_ok_3(ok_o[2]),
      .seq_gap_1(gap_o[0]), .seq_gap_2(gap_o[1]), .seq_gap_3(gap_o[2]),
      .seq_dup_1(dup_o[0]), .seq_dup_2(dup_o[1]), .seq_dup_3(dup_o[2]),
      .gap_len_1(glen_o[0]), .gap_len_2(glen_o[1]), .gap_len_3(glen_o[2]),
      .gap_cnt_1(cnt_o[0]), .gap_cnt_2(cnt_o[1]), .gap_cnt_3(cnt_o[2])
   );

   task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s lane%0d actual=%h expected=%h at %0t", name, l + 1, act, expv, $time);
      end
   endtask

   // Reference model: applies the sequence rules to each qualified message at the clock edge.
   task automatic model_edge();
      exp_t        e;
      logic [31:0] d;
      if (rst) begin
         for (int l = 0; l < 3; l++) begin
            sbq[l].delete();
            synced[l] = 0;
            ex_m[l]   = '0;
            hq[l]     = '0;
            hcnt[l]   = 0;
         end
      end else begin
         for (int l = 0; l < 3; l++) begin
            if (resync) synced[l] = 0;
            if (en && mux[l] == 4'd1 && nt[l] == 4'd1) begin
               e = '{b: bsn[l], ok: 0, gap: 0, dup: 0, glen: 32'd0, cnt: 0};
               d = bsn[l] - ex_m[l];
               if (!synced[l] || d == 32'd0) begin
                  e.ok = 1;
                  ex_m[l] = bsn[l] + 32'd1;
                  synced[l] = 1;
               end else if (d < 32'h8000_0000) begin
                  e.gap = 1;
                  e.glen = d;
                  ex_m[l] = bsn[l] + 32'd1;
                  hcnt[l] = (hcnt[l] == (1 << CW) - 1) ? hcnt[l] : hcnt[l] + 1;
               end else begin
                  e.dup = 1;
               end
               e.cnt = hcnt[l];
               hq[l] = bsn[l];
               sbq[l].push_back(e);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0;
      resync = 0;
      en = 1;
      for (int l = 0; l < 3; l++) begin
         mux[l] = 4'd0;
         nt[l]  = 4'd1;
         bsn[l] = $urandom;
      end
   endtask

   task automatic lane(input int l, input logic [31:0] b);
      mux[l] = 4'd1;
      nt[l]  = 4'd1;
      bsn[l] = b;
   endtask

   // Monitor: pops an expectation for each strobe, otherwise checks idle outputs and held values.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int l = 0; l < 3; l++) begin
            if (vld_o[l] === 1'b1) begin
               if (sbq[l].size() == 0) begin
                  chk("unexpected_vld", l, 32'd1, 32'd0);
               end else begin
                  e = sbq[l].pop_front();
                  chk("bsn4_q", l, q_o[l], e.b);
                  chk("seq_ok", l, {31'd0, ok_o[l]}, {31'd0, e.ok});
                  chk("seq_gap", l, {31'd0, gap_o[l]}, {31'd0, e.gap});
                  chk("seq_dup", l, {31'd0, dup_o[l]}, {31'd0, e.dup});
                  chk("gap_len", l, glen_o[l], e.glen);
                  chk("gap_cnt", l, 32'(cnt_o[l]), 32'(e.cnt));
               end
            end else begin
               chk("seq_vld", l, {31'd0, vld_o[l]}, 32'd0);
               chk("idle_flags", l, {29'd0, ok_o[l], gap_o[l], dup_o[l]}, 32'd0);
               chk("idle_gap_len", l, glen_o[l], 32'd0);
               chk("held_bsn4_q", l, q_o[l], hq[l]);
               chk("held_gap_cnt", l, 32'(cnt_o[l]), 32'(hcnt[l]));
               if (sbq[l].size() != 0) begin
                  chk("missing_vld", l, 32'd0, 32'd1);
                  void'(sbq[l].pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] seq3 [5];
      int          r;
      seq3 = '{32'd50, 32'd51, 32'd51, 32'd49, 32'd52};
      idle();
      rst = 1;
      tick();
      tick();
      idle();
      for (int k = 0; k < 3; k++) begin idle(); lane(0, 32'(100 + k)); tick(); end
      idle(); lane(1, 32'd10); tick();
      idle(); lane(1, 32'd15); tick();
      idle(); lane(1, 32'd16); tick();
      for (int k = 0; k < 5; k++) begin idle(); lane(2, seq3[k]); tick(); end
      idle(); resync = 1; lane(0, 32'hFFFF_FFFE); tick();
      idle(); lane(0, 32'hFFFF_FFFF); tick();
      idle(); lane(0, 32'h0000_0000); tick();
      for (int k = 0; k < 3; k++) begin idle(); lane(0, 32'd1000 + 32'(k)); en = 0; tick(); end
      for (int k = 0; k < 3; k++) begin idle(); lane(0, 32'd2000 + 32'(k)); mux[0] = 4'd2; tick(); end
      idle(); lane(0, 32'd1); tick();
      idle(); lane(0, 32'd199); tick();
      idle(); resync = 1; lane(0, 32'd500); tick();
      idle(); lane(0, 32'd501); tick();
      idle(); rst = 1; tick();
      idle(); lane(1, 32'd0); tick();
      for (int k = 1; k <= 5; k++) begin idle(); lane(1, 32'(2 * k)); tick(); end
      idle(); rst = 1; lane(1, 32'd11); lane(0, 32'd7); tick();
      idle(); tick();
      idle(); lane(1, 32'd77); tick();
      idle(); lane(0, 32'hFFFF_FFF0); lane(2, 32'h7FFF_FFFF); tick();
      for (int c = 0; c < 600; c++) begin
         idle();
         rst    = ($urandom_range(0, 149) == 0);
         resync = ($urandom_range(0, 29) == 0);
         en     = ($urandom_range(0, 7) != 0);
         for (int l = 0; l < 3; l++) begin
            mux[l] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2)) : 4'd1;
            nt[l]  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 2)) : 4'd1;
            r = $urandom_range(0, 9);
            if (r < 5)      bsn[l] = ex_m[l];
            else if (r < 7) bsn[l] = ex_m[l] + 32'($urandom_range(1, 6));
            else if (r < 9) bsn[l] = ex_m[l] - 32'($urandom_range(1, 4));
            else            bsn[l] = $urandom;
         end
         tick();
      end
      idle();
      tick();
      tick();
      for (int l = 0; l < 3; l++) chk("drained", l, 32'(sbq[l].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stage6_bsn4_seq_check.md
Name: stage6_bsn4_seq_check

Overview:
- Sequential stage directly downstream of the stage-5 BSN4 field extractor.
- Consumes the three per-lane BSN4 sequence numbers, qualified by the same message enable and mux/type controls.
- Tracks the expected next BSN per lane and flags in-order, gap and stale/duplicate messages.
- Keeps saturating per-lane gap counters for the stage-7 recovery/statistics logic.

Parameters:
- BSN_W, 32, width of BSN4 field (equals `field_BSN4_bits).
- MUXW, 4, width of message_mux_control (equals `message_mux_control_width).
- NTW, 4, width of N_type_control (equals `N_type_control_width).
- MUX_N, 4'd1, mux code for N messages (`message_mux_N).
- TYPE_M, 4'd1, N-type code for M messages (`N_type_M).
- CNT_W, 16, width of gap counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- message_en  input  1  global message enable, same cycle as BSN4 inputs.
- message_mux_control_m1/_m2/_m3  input  MUXW each  per-lane message mux code.
- N_type_control_m1/_m2/_m3  input  NTW each  per-lane N-type code.
- BSN4_1/_2/_3  input  BSN_W each  extracted BSN4 per lane.
- resync  input  1  one-cycle pulse; returns all lanes to UNSYNC.
- bsn4_q_1/_2/_3  output  BSN_W each  registered BSN4.
- seq_vld_1/_2/_3  output  1 each  result valid strobe.
- seq_ok_1/_2/_3  output  1 each  first-after-sync or in-order message.
- seq_gap_1/_2/_3  output  1 each  forward gap detected.
- seq_dup_1/_2/_3  output  1 each  stale or duplicate BSN.
- gap_len_1/_2/_3  output  BSN_W each  missing message count for this gap.
- gap_cnt_1/_2/_3  output  CNT_W each  saturating total gap events.

Behaviour:
- Lane valid: v_i = message_en && (mux_i == MUX_N) && (ntype_i == TYPE_M). BSN4_i is ignored when v_i = 0.
- All outputs are registered with 1-cycle latency: lane input at edge k produces results after edge k+1.
- Reset (rst = 1 at an edge):
  - All outputs go to 0.
  - Lane state goes to UNSYNC and exp_i to 0.
  - An in-flight input that cycle is discarded.
- Per-lane FSM with two states, UNSYNC and TRACK:
  - UNSYNC, v_i: seq_ok = 1; exp_i = BSN4_i + 1 (mod 2^BSN_W); go to TRACK.
  - TRACK, v_i: d = (BSN4_i - exp_i) mod 2^BSN_W.
    - d == 0: seq_ok = 1; exp_i = exp_i + 1.
    - 0 < d < 2^(BSN_W-1): seq_gap = 1; gap_len = d; exp_i = BSN4_i + 1; gap_cnt increments.
    - d >= 2^(BSN_W-1): seq_dup = 1; exp_i unchanged.
  - v_i = 0: state and exp_i hold; seq_vld/ok/gap/dup = 0.
- Output flags and held values:
  - Exactly one of ok/gap/dup is set whenever seq_vld = 1; none is set otherwise.
  - gap_len is 0 except on a seq_gap cycle.
  - bsn4_q updates only on valid; it holds otherwise.
- Wrap-around: exp_i wraps modulo 2^BSN_W. Example: BSN 0xFFFFFFFF followed by 0x00000000 is in-order.
- gap_cnt saturates at 2^CNT_W - 1 and never wraps. It is cleared only by rst; resync does not clear it.
- resync:
  - Sets all lanes to UNSYNC.
  - If v_i is asserted in the same cycle, that message is processed as the first message in UNSYNC: seq_ok = 1 and exp_i = BSN4_i + 1.
- Lanes are fully independent. Simultaneous valid on all three lanes is processed in the same cycle.
- rst takes priority over resync and all inputs.

Test Plan:
- Reset and sync:
  - Stimulus: rst for 2 cycles, then lane1 valid BSN 100, 101, 102 back-to-back.
  - Response: seq_vld_1 with seq_ok_1 on 3 consecutive cycles, 1 cycle after each input; bsn4_q_1 = 100, 101, 102; gap_cnt_1 = 0.
- Gap:
  - Stimulus: lane2 sync at 10, then 15.
  - Response: seq_gap_2 = 1, gap_len_2 = 4, gap_cnt_2 = 1; a following 16 gives seq_ok_2.
- Duplicate/stale:
  - Stimulus: lane3 sequence 50, 51, 51, 49, 52.
  - Response: flags ok, ok, dup, dup, ok; gap_cnt_3 stays 0.
- Wrap and qualification:
  - Stimulus 1: lane1 sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000. Response: all ok.
  - Stimulus 2: the same sequence with message_en = 0, or with mux_control != MUX_N. Response: no seq_vld and state unchanged.
- Resync collision:
  - Stimulus: lane1 in TRACK with exp = 200; pulse resync with lane1 valid BSN 500 in the same cycle.
  - Response: seq_ok_1 = 1 (no gap); a next input of 501 gives ok.
- Saturation and mid-stream reset:
  - Stimulus 1: with CNT_W = 2, lane2 takes 5 gap events. Response: gap_cnt_2 = 3.
  - Stimulus 2: rst asserted while a valid input is presented. Response: outputs 0 the next cycle; the next valid input gives seq_ok.
